// File: rtl/ccu_seq_pkg.sv
// rtl/ccu_seq_pkg.sv - shared opcodes, FSM states and instruction fields for the CCU sequencer
package ccu_seq_pkg;

  localparam logic [3:0] OP_ALU_MAX = 4'h7;
  localparam logic [3:0] OP_LOAD    = 4'h8;
  localparam logic [3:0] OP_JMP     = 4'hC;
  localparam logic [3:0] OP_BRCC    = 4'hD;
  localparam logic [3:0] OP_KOUT    = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int R_MSB   = 11;
  localparam int R_LSB   = 8;
  localparam int A_MSB   = 7;
  localparam int A_LSB   = 4;
  localparam int B_MSB   = 3;
  localparam int B_LSB   = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MREQ,
    S_MWR
  } state_e;

  // r[1:0] picks the condition bit, r[2] is the polarity it must match.
  function automatic logic br_taken(input logic [3:0] cc, input logic [3:0] r);
    return cc[r[1:0]] == r[2];
  endfunction

endpackage

// File: rtl/ccu_instr_decode.sv
// rtl/ccu_instr_decode.sv - combinational micro-instruction decoder
module ccu_instr_decode
  import ccu_seq_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic        is_alu_o,
  output logic        is_load_o,
  output logic        is_jmp_o,
  output logic        is_br_o,
  output logic        is_kout_o,
  output logic        is_halt_o,
  output logic [3:0]  op_o,
  output logic [3:0]  r_o,
  output logic [3:0]  a_o,
  output logic [3:0]  b_o,
  output logic [7:0]  imm_o
);

  logic [3:0] op;

  assign op        = instr_i[OP_MSB:OP_LSB];
  assign op_o      = op;
  assign r_o       = instr_i[R_MSB:R_LSB];
  assign a_o       = instr_i[A_MSB:A_LSB];
  assign b_o       = instr_i[B_MSB:B_LSB];
  assign imm_o     = instr_i[IMM_MSB:IMM_LSB];

  assign is_alu_o  = (op <= OP_ALU_MAX);
  assign is_load_o = (op == OP_LOAD);
  assign is_jmp_o  = (op == OP_JMP);
  assign is_br_o   = (op == OP_BRCC);
  assign is_kout_o = (op == OP_KOUT);
  assign is_halt_o = (op == OP_HALT);

endmodule

// File: rtl/ccu_sequencer.sv
// rtl/ccu_sequencer.sv - microprogram sequencer driving the CCU datapath selects and opcode
module ccu_sequencer
  import ccu_seq_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [3:0] IDLE_OP = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic [PC_W-1:0] rom_addr,
  output logic            rom_en,
  input  logic [15:0]     rom_data,
  output logic [3:0]      abus,
  output logic [3:0]      bbus,
  output logic [3:0]      rbus,
  output logic [3:0]      n,
  input  logic [3:0]      cc,
  output logic            mem_req,
  output logic [7:0]      mem_addr,
  input  logic            mem_ack,
  output logic            kbus_valid,
  output logic            busy,
  output logic            done
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      cc_q, cc_d;

  logic [PC_W-1:0] rom_addr_q, rom_addr_d;
  logic            rom_en_q, rom_en_d;
  logic [3:0]      abus_q, abus_d;
  logic [3:0]      bbus_q, bbus_d;
  logic [3:0]      rbus_q, rbus_d;
  logic [3:0]      n_q, n_d;
  logic            mem_req_q, mem_req_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic            kbus_valid_q, kbus_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [15:0] dec_word;
  logic        is_alu, is_load, is_jmp, is_br, is_kout, is_halt;
  logic [3:0]  dec_op, dec_r, dec_a, dec_b;
  logic [7:0]  dec_imm;

  // Outputs are registered, so the EXEC-cycle values are computed while still in
  // DECODE, straight from the ROM word; afterwards the latched ir is decoded.
  assign dec_word = (state_q == S_DECODE) ? rom_data : ir_q;

  ccu_instr_decode u_decode (
    .instr_i   (dec_word),
    .is_alu_o  (is_alu),
    .is_load_o (is_load),
    .is_jmp_o  (is_jmp),
    .is_br_o   (is_br),
    .is_kout_o (is_kout),
    .is_halt_o (is_halt),
    .op_o      (dec_op),
    .r_o       (dec_r),
    .a_o       (dec_a),
    .b_o       (dec_b),
    .imm_o     (dec_imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = is_load ? S_MREQ : S_EXEC;
      S_EXEC:   state_d = is_halt ? S_IDLE : S_FETCH;
      S_MREQ:   if (mem_ack) state_d = S_MWR;
      S_MWR:    state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    cc_d         = cc_q;
    n_d          = IDLE_OP;
    rbus_d       = 4'h0;
    abus_d       = 4'h0;
    bbus_d       = 4'h0;
    mem_addr_d   = mem_addr_q;
    kbus_valid_d = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) pc_d = start_pc;
      end
      S_DECODE: begin
        ir_d         = rom_data;
        kbus_valid_d = is_kout;
        if (is_alu) begin
          n_d    = dec_op;
          rbus_d = dec_r;
          abus_d = dec_a;
          bbus_d = dec_b;
        end
        if (is_load) mem_addr_d = dec_imm;
      end
      S_EXEC: begin
        if (is_alu) cc_d = cc;
        if (is_jmp || (is_br && br_taken(cc_q, dec_r))) begin
          pc_d = PC_W'(dec_imm);
        end else begin
          pc_d = pc_q + PC_ONE;
        end
        done_d = is_halt;
      end
      S_MREQ: begin
        // The n=8 write is only scheduled on the ack edge, never speculatively.
        if (mem_ack) begin
          n_d    = OP_LOAD;
          rbus_d = dec_r;
        end
      end
      S_MWR: begin
        pc_d = pc_q + PC_ONE;
      end
      default: ;
    endcase
    rom_addr_d = pc_d;
    rom_en_d   = (state_d == S_FETCH);
    mem_req_d  = (state_d == S_MREQ);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= '0;
      ir_q         <= 16'h0;
      cc_q         <= 4'h0;
      rom_addr_q   <= '0;
      rom_en_q     <= 1'b0;
      abus_q       <= 4'h0;
      bbus_q       <= 4'h0;
      rbus_q       <= 4'h0;
      n_q          <= IDLE_OP;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 8'h0;
      kbus_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      cc_q         <= cc_d;
      rom_addr_q   <= rom_addr_d;
      rom_en_q     <= rom_en_d;
      abus_q       <= abus_d;
      bbus_q       <= bbus_d;
      rbus_q       <= rbus_d;
      n_q          <= n_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      kbus_valid_q <= kbus_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_en     = rom_en_q;
  assign abus       = abus_q;
  assign bbus       = bbus_q;
  assign rbus       = rbus_q;
  assign n          = n_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign kbus_valid = kbus_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ccu_sequencer.sv
// tb/tb_ccu_sequencer.sv - directed table-driven bench for ccu_sequencer
module tb_ccu_sequencer;

  localparam logic [3:0]  IDLE_N = 4'hF;
  localparam logic [15:0] HALT_W = 16'hF000;
  localparam int          NV     = 12;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [3:0]  n;
    logic [3:0]  r;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        kv;
    logic        halt;
    logic [7:0]  nxt;
  } vec_t;

  typedef struct packed {
    logic [3:0]  cc_alu;
    logic [15:0] instr;
    logic [7:0]  exp;
  } br_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_pc = 8'h0;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [15:0] rom_data = 16'h0;
  logic [3:0]  abus, bbus, rbus, n;
  logic [3:0]  cc = 4'h0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic        kbus_valid, busy, done;

  logic [15:0] rom_mem [256];
  vec_t        vecs [NV];
  br_t         brs [3];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  ccu_sequencer #(.PC_W(8), .IDLE_OP(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_pc   (start_pc),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .abus       (abus),
    .bbus       (bbus),
    .rbus       (rbus),
    .n          (n),
    .cc         (cc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .kbus_valid (kbus_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic kick(input logic [7:0] pc);
    start_pc = pc;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   req_cnt, n8_cnt, bad, last_req, n8_idx, done_idx, kv_idx, idle_idx, kv_cnt, dn_cnt, stray;
    logic [7:0] fetch_addr;

    for (int i = 0; i < 256; i++) rom_mem[i] = HALT_W;
    vecs[0]  = '{8'h10, 16'h3A12, 4'h3, 4'hA, 4'h1, 4'h2, 1'b0, 1'b0, 8'h11};
    vecs[1]  = '{8'h20, 16'h7FFF, 4'h7, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 8'h21};
    vecs[2]  = '{8'h21, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h22};
    vecs[3]  = '{8'h30, 16'h9123, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h31};
    vecs[4]  = '{8'h31, 16'hB456, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h32};
    vecs[5]  = '{8'h40, 16'hC0FF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'hFF};
    vecs[6]  = '{8'h41, 16'hE000, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h42};
    vecs[7]  = '{8'h42, 16'hF000, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{8'hFF, 16'h5123, 4'h5, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{8'h50, 16'hD07A, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h7A};
    vecs[10] = '{8'h50, 16'hD47A, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h51};
    vecs[11] = '{8'h60, 16'hA0FF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h61};
    brs[0] = '{4'b0100, 16'hD640, 8'h40};
    brs[1] = '{4'b0000, 16'hD640, 8'h52};
    brs[2] = '{4'b1011, 16'hD240, 8'h40};

    do_reset();
    chk("rst_rom", 32'({rom_en, rom_addr}), 32'h0);
    chk("rst_dp", 32'({n, rbus, abus, bbus}), 32'({IDLE_N, 12'h0}));
    chk("rst_mem", 32'({mem_req, mem_addr}), 32'h0);
    chk("rst_ctl", 32'({kbus_valid, busy, done}), 32'h0);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      do_reset();
      rom_mem[v.pc] = v.instr;
      kick(v.pc);
      chk("v_fetch", 32'({rom_en, busy, rom_addr}), 32'({2'b11, v.pc}));
      cyc();
      chk("v_decode", 32'({n, rbus, abus, bbus}), 32'({IDLE_N, 12'h0}));
      cyc();
      chk("v_exec", 32'({n, rbus, abus, bbus}), 32'({v.n, v.r, v.a, v.b}));
      chk("v_exec_ctl", 32'({busy, done, kbus_valid}), 32'({2'b10, v.kv}));
      cyc();
      if (v.halt) chk("v_halt", 32'({busy, done, rom_en}), 32'(3'b010));
      else chk("v_next", 32'({rom_en, rom_addr, done, kbus_valid}), 32'({1'b1, v.nxt, 2'b00}));
      rom_mem[v.pc] = HALT_W;
    end

    // LOAD with ack on the fourth MREQ cycle, plus a stray ack during FETCH
    do_reset();
    rom_mem[8'h30] = 16'h8905;
    kick(8'h30);
    req_cnt = 0; n8_cnt = 0; bad = 0; last_req = -1; n8_idx = -1; done_idx = -1;
    fetch_addr = 8'h0;
    for (int i = 1; i <= 12; i++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cnt++;
        last_req = i;
        if (mem_addr !== 8'h05) bad++;
      end
      if (n === 4'h8) begin
        n8_cnt++;
        n8_idx = i;
        if (rbus !== 4'h9) bad++;
      end else if (n !== IDLE_N) bad++;
      if (done && done_idx < 0) done_idx = i;
      if (i == 8 && rom_en) fetch_addr = rom_addr;
      if (i == 1) mem_ack = 1'b1;
      if (mem_req && req_cnt == 4) mem_ack = 1'b1;
      cyc();
    end
    mem_ack = 1'b0;
    chk("ld_req_cnt", 32'(req_cnt), 32'd4);
    chk("ld_req_last", 32'(last_req), 32'd6);
    chk("ld_n8_cnt", 32'(n8_cnt), 32'd1);
    chk("ld_n8_idx", 32'(n8_idx), 32'd7);
    chk("ld_bad", 32'(bad), 32'd0);
    chk("ld_next_fetch", 32'(fetch_addr), 32'h31);
    chk("ld_done_idx", 32'(done_idx), 32'd11);

    // branch on cc_q captured by the preceding ALU op; live cc is flipped meanwhile
    for (int i = 0; i < 3; i++) begin
      do_reset();
      rom_mem[8'h50] = 16'h1000;
      rom_mem[8'h51] = brs[i].instr;
      cc = brs[i].cc_alu;
      kick(8'h50);
      cyc(); cyc(); cyc();
      cc = ~brs[i].cc_alu;
      chk("br_fetch", 32'({rom_en, rom_addr}), 32'({1'b1, 8'h51}));
      cyc(); cyc(); cyc();
      chk("br_target", 32'({rom_en, rom_addr}), 32'({1'b1, brs[i].exp}));
      rom_mem[8'h50] = HALT_W;
      rom_mem[8'h51] = HALT_W;
    end
    cc = 4'h0;

    // JMP to 0xFF then NOP wraps the pc
    do_reset();
    rom_mem[8'hFE] = 16'hC0FF;
    rom_mem[8'hFF] = 16'h9000;
    kick(8'hFE);
    cyc(); cyc(); cyc();
    chk("jmp_target", 32'({rom_en, rom_addr}), 32'({1'b1, 8'hFF}));
    cyc(); cyc(); cyc();
    chk("wrap_fetch", 32'({rom_en, rom_addr}), 32'({1'b1, 8'h00}));
    rom_mem[8'hFE] = HALT_W;
    rom_mem[8'hFF] = HALT_W;

    // KOUT then HALT, with start pulses while busy
    do_reset();
    rom_mem[8'h60] = 16'hE000;
    kick(8'h60);
    kv_cnt = 0; dn_cnt = 0; kv_idx = -1; done_idx = -1; idle_idx = -1; stray = 0;
    for (int i = 1; i <= 10; i++) begin
      start = 1'b0;
      if (kbus_valid) begin kv_cnt++; kv_idx = i; end
      if (done) begin dn_cnt++; done_idx = i; end
      if (!busy && idle_idx < 0) idle_idx = i;
      if (rom_en && rom_addr == 8'h70) stray++;
      if (i == 2 || i == 5) begin
        start_pc = 8'h70;
        start    = 1'b1;
      end
      cyc();
    end
    start = 1'b0;
    chk("kout_cnt", 32'(kv_cnt), 32'd1);
    chk("kout_idx", 32'(kv_idx), 32'd3);
    chk("done_cnt", 32'(dn_cnt), 32'd1);
    chk("done_idx", 32'(done_idx), 32'd7);
    chk("busy_fall_idx", 32'(idle_idx), 32'd7);
    chk("busy_start_ignored", 32'(stray), 32'd0);
    rom_mem[8'h60] = HALT_W;

    // asynchronous reset in the middle of MREQ
    do_reset();
    kick(8'h30);
    cyc(); cyc();
    chk("mreq_before_rst", 32'({mem_req, busy}), 32'(2'b11));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({mem_req, n, busy, rom_en, mem_addr}), 32'({1'b0, IDLE_N, 2'b00, 8'h00}));
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1'b1;
      if (busy || rom_en || mem_req || (n !== IDLE_N)) bad++;
      cyc();
    end
    mem_ack = 1'b0;
    chk("idle_after_rst", 32'(bad), 32'd0);
    kick(8'h10);
    chk("restart_fetch", 32'({rom_en, busy, rom_addr}), 32'({2'b11, 8'h10}));
    cyc(); cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ccu_sequencer.md
# ccu_sequencer

Microprogram sequencer for the CCU datapath unit. It fetches 16-bit micro-instructions from an external synchronous ROM and drives the datapath's register selects (Abus/Bbus/Rbus) and opcode (n). It runs the memory-load handshake for n=8 writes, and branches on the datapath's condition codes. It sits between the CCU host control (start/done) and the datapath, and flags when the 24-bit Kbus colour word is ready.

## Interface
Parameters
- PC_W, 8, ROM address width; the program wraps at 2^PC_W.
- IDLE_OP, 4'hF, opcode driven on n when no datapath operation is active.

Ports
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at start_pc. Ignored unless in IDLE.
- start_pc  in  PC_W  entry address, sampled with start.
- rom_addr  out  PC_W  micro-instruction address.
- rom_en  out  1  ROM read strobe; data is valid one cycle later.
- rom_data  in  16  micro-instruction.
- abus, bbus, rbus  out  4  datapath register selects.
- n  out  4  datapath opcode.
- cc  in  4  datapath condition codes (combinational from ALU).
- mem_req  out  1  load request; held until mem_ack.
- mem_addr  out  8  load address.
- mem_ack  in  1  memory data is valid on the datapath mData this cycle.
- kbus_valid  out  1  one-cycle pulse: Kbus holds a finished colour word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on HALT.

## Operation
- Instruction word: [15:12] op, [11:8] r, [7:4] a, [3:0] b. The 8-bit immediate is [7:0].
- op 0x0–0x7 (ALU): drive n=op, rbus=r, abus=a, bbus=b for one EXEC cycle. cc_q <= cc at the end of EXEC.
- op 0x8 (LOAD): mem_addr=imm, then run the handshake. On ack, drive n=8 and rbus=r for one cycle.
- op 0x9–0xB: NOP. Consumes a full fetch/decode/exec sequence.
- op 0xC (JMP): pc <= imm[PC_W-1:0].
- op 0xD (BRcc): if cc_q[r[1:0]] == r[2], pc <= imm; otherwise pc+1. r[3] is reserved and must be 0.
- op 0xE (KOUT): pulse kbus_valid.
- op 0xF (HALT): pulse done and return to IDLE.
- FSM states: IDLE, FETCH, DECODE, EXEC, MREQ, MWR.
  - IDLE -start-> FETCH (pc <= start_pc)
  - FETCH -> DECODE (ir latched from rom_data at the end of DECODE)
  - DECODE -> MREQ if LOAD, else EXEC
  - EXEC -> FETCH, or IDLE for HALT
  - MREQ -mem_ack-> MWR
  - MWR -> FETCH
- pc increments by 1 modulo 2^PC_W. 0xFF+1 wraps to 0x00.
- Outside EXEC/MWR: n=IDLE_OP, selects=0. The datapath must never see a stray n=8.
- cc_q updates only on ALU EXEC cycles. LOAD, NOP and branches leave it unchanged.

## Timing
- Reset values: rom_addr=0, rom_en=0, abus=bbus=rbus=0, n=IDLE_OP, mem_req=0, mem_addr=0, kbus_valid=0, busy=0, done=0. Also pc=0, ir=0, cc_q=0, state=IDLE.
- All outputs are registered.
- rom_en is high only in FETCH.
- Latency per instruction:
  - ALU, NOP, JMP, BRcc, KOUT: 3 cycles.
  - LOAD: 4 + (wait cycles before mem_ack).
- The start→first rom_en latency is 1 cycle.
- mem_req rises in the first MREQ cycle and stays high, with mem_addr stable, through the cycle mem_ack is seen. It falls in MWR.
- mem_ack outside MREQ is ignored. mem_ack in the first MREQ cycle gives the minimum 4-cycle LOAD.
- start while busy is ignored; there is no queueing.
- rst asserted mid-instruction (including during MREQ) immediately clears every output to its reset value. No partial n=8 write is issued.
- done and kbus_valid are single-cycle even when HALT/KOUT instructions are back-to-back.

## Structure
- Package ccu_seq_pkg holds:
  - opcode constants (OP_LOAD=4'h8, OP_JMP=4'hC, OP_BRCC=4'hD, OP_KOUT=4'hE, OP_HALT=4'hF);
  - the state enum;
  - the instruction field bit positions.
- Sub-module ccu_instr_decode: a combinational decoder from ir to {is_alu, is_load, is_jmp, is_br, is_kout, is_halt, fields}.
- The FSM, pc and cc_q live in ccu_sequencer.

## Test plan
- Reset then start with start_pc=0x10; ROM[0x10]=0x3A12 (ALU):
  - rom_addr=0x10 one cycle after start;
  - two cycles later n=3, rbus=0xA, abus=1, bbus=2 for exactly one cycle;
  - next rom_addr=0x11.
- LOAD 0x8905 with mem_ack delayed 3 cycles:
  - mem_req is high for 4 cycles with mem_addr=0x05;
  - then n=8, rbus=9 for one cycle;
  - n=IDLE_OP at all other times.
- ALU op with cc=4'b0100, then BRcc 0xD640 (bit2 == 1) → rom_addr=0x40. Repeat with cc=0 → fall-through to pc+1.
- JMP 0xC0FF at 0xFE, then NOP at 0xFF → next fetch at 0x00 (wrap).
- Sequence KOUT, HALT:
  - kbus_valid pulses once;
  - done pulses once;
  - busy falls the same cycle as done;
  - a start pulse asserted while busy earlier had no effect.
- Assert rst during MREQ → mem_req=0, n=IDLE_OP, busy=0 asynchronously. After release, the block sits in IDLE until the next start.
